freq_gen8: RTL and testbench

//  Generates the 8 binary-related clock-enable waveforms that feed the 8:1 frequency

---
 rtl/freq_gen8.sv | 39 +++
 tb/tb_freq_gen8.sv | 127 ++++++++++++
 2 files changed

// File: rtl/freq_gen8.sv
// freq_gen8: prescaled 8-bit binary divide chain driving registered clk_div taps and rising-edge ticks
// Define FREQ_GEN_CLR_EN to add the synchronous phase-restart input clr
module freq_gen8 #(
    parameter int BASE_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
`ifdef FREQ_GEN_CLR_EN
    input  logic       clr,
`endif
    output logic [7:0] clk_div,
    output logic [7:0] tick
);
    localparam int PRE_W = $clog2(BASE_DIV);
    logic [PRE_W-1:0] pre_cnt;
    logic             step;
    logic             restart;
    logic [7:0]       rise;
`ifdef FREQ_GEN_CLR_EN
    assign restart = clr;
`else
    assign restart = 1'b0;
`endif
    assign step = en && (pre_cnt == PRE_W'(BASE_DIV - 1));
    // the increment carries through the trailing ones, so only the lowest zero bit rises
    assign rise = (clk_div + 8'd1) & ~clk_div;
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            pre_cnt <= '0;
            clk_div <= 8'h00;
            tick    <= 8'h00;
        end else begin
            tick <= step ? rise : 8'h00;
            if (en) pre_cnt <= step ? '0 : pre_cnt + PRE_W'(1);
            if (step) clk_div <= clk_div + 8'd1;
        end
    end
endmodule

// File: tb/tb_freq_gen8.sv
// tb_freq_gen8: scoreboard bench for freq_gen8 with BASE_DIV=4
// Stimulus pushes per-edge expectations; a negedge monitor pops and compares
module tb_freq_gen8;
    localparam int BD = 4;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
`ifdef FREQ_GEN_CLR_EN
    logic       clr = 1'b0;
`endif
    logic [7:0] clk_div;
    logic [7:0] tick;
    logic [15:0] exp_q[$];
    string       name_q[$];
    int          checks = 0;
    int          passes = 0;
    int          mdl_pre = 0;
    logic [7:0]  mdl_cnt = 8'h00;
    logic [7:0]  mdl_tk = 8'h00;
    logic [15:0] exp_v;
    string       exp_n;

    freq_gen8 #(.BASE_DIV(BD)) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
`ifdef FREQ_GEN_CLR_EN
        .clr(clr),
`endif
        .clk_div(clk_div),
        .tick(tick)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            exp_n = name_q.pop_front();
            checks++;
            if ({clk_div, tick} === exp_v) passes++;
            else $display("FAIL %s: got clk_div=%h tick=%h, expected clk_div=%h tick=%h",
                          exp_n, clk_div, tick, exp_v[15:8], exp_v[7:0]);
        end
    end

    task automatic step(input logic r, input logic e, input logic c, input bit hand = 1'b0,
                        input logic [7:0] hcd = 8'h00, input logic [7:0] htk = 8'h00,
                        input string nm = "model");
        logic [7:0] old;
        rst = r;
        en = e;
`ifdef FREQ_GEN_CLR_EN
        clr = c;
`endif
        @(posedge clk);
        #1;
        if (r || c) begin
            mdl_pre = 0;
            mdl_cnt = 8'h00;
            mdl_tk = 8'h00;
        end else if (e && mdl_pre == BD - 1) begin
            mdl_pre = 0;
            old = mdl_cnt;
            mdl_cnt = mdl_cnt + 8'd1;
            mdl_tk = mdl_cnt & ~old;
        end else begin
            if (e) mdl_pre++;
            mdl_tk = 8'h00;
        end
        exp_q.push_back(hand ? {hcd, htk} : {mdl_cnt, mdl_tk});
        name_q.push_back(nm);
    endtask

    task automatic run_until(input logic [7:0] cnt, input int pre);
        for (int i = 0; i < 3000 && !(mdl_cnt == cnt && mdl_pre == pre); i++) step(1'b0, 1'b1, 1'b0);
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, "reset_hold");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, "first_latency");
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 8'h01, "first_step");
        run_n(3);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h02, 8'h02, "tick1_rise");
        run_n(3);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h03, 8'h01, "tick0_again");
        run_n(3);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h04, 8'h04, "tick2_rise");
        run_n(3);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h05, 8'h01, "reach_05");
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 8'h05, 8'h00, "pause_hold");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 8'h05, 8'h00, "resume_phase");
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h06, 8'h02, "resume_step");
        run_n(3);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h06, 8'h00, "en_low_at_wrap");
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h07, 8'h01, "en_high_at_wrap");
        run_until(8'h7F, BD - 1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h80, 8'h80, "msb_rise");
        run_n(3);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h81, 8'h01, "after_msb");
        run_until(8'hFF, BD - 1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, "wrap_ff");
        run_until(8'h2A, 1);
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, "rst_mid");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, "rst_latency");
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 8'h01, "rst_first_step");
`ifdef FREQ_GEN_CLR_EN
        run_until(8'h33, 2);
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, "clr_pulse");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, "clr_latency");
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 8'h01, "clr_first_step");
`endif
        run_n(8);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            checks++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
